// File: rtl/sha2_pkg.sv
// Shared SHA-256/224 constants, round functions and FSM encoding.
package sha2_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
    word_t e;
    word_t f;
    word_t g;
    word_t h;
  } work_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;

  localparam work_t IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam work_t IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha2_round.sv
// One combinational SHA-2 compression round: working variables in, next working variables out.
module sha2_round
  import sha2_pkg::*;
(
  input  work_t cur,
  input  word_t w,
  input  word_t k,
  output work_t nxt
);

  word_t t1;
  word_t t2;

  always_comb begin
    t1  = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
    t2  = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);
    nxt = '{a: t1 + t2, b: cur.a, c: cur.b, d: cur.c,
            e: cur.d + t1, f: cur.e, g: cur.f, h: cur.g};
  end

endmodule

// File: rtl/sha2_round_engine.sv
// SHA-256/224 block compression with UNROLL rounds per clock and a held chaining digest.
//
// state    | meaning
// ST_IDLE  | waiting for START; DIGEST holds the last result
// ST_ROUND | UNROLL rounds plus schedule steps per cycle
// ST_FINAL | feed-forward add into H, DONE pulse
module sha2_round_engine
  import sha2_pkg::*;
#(
  parameter int UNROLL = 1
)
(
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic         FIRST,
  input  logic         MODE224,
  input  logic [511:0] BLOCK,
  output logic         BUSY,
  output logic         DONE,
  output logic [255:0] DIGEST
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 && UNROLL != 16) begin : g_bad_unroll
    $error("sha2_round_engine: UNROLL must be 1, 2, 4, 8 or 16");
  end

  localparam logic [5:0] T_STEP = 6'(UNROLL);

  logic [1:0]   state_q;
  logic [5:0]   t_q;
  logic         mode224_q;
  logic         done_q;
  work_t        h_q;
  work_t        work_q;
  logic [511:0] w_q;

  logic [511:0] win_last;
  work_t        work_last;
  work_t        h_sum;
  work_t        iv_sel;
  logic         last_step;

  // Window word 0 sits at the MSB end; each round drops it and appends the new word at the LSB end.
  for (genvar i = 0; i < UNROLL; i++) begin : g_round
    logic [511:0] win_in;
    logic [511:0] win_out;
    work_t        st_in;
    work_t        st_out;
    word_t        nw;

    if (i == 0) begin : g_head
      assign win_in = w_q;
      assign st_in  = work_q;
    end else begin : g_link
      assign win_in = g_round[i-1].win_out;
      assign st_in  = g_round[i-1].st_out;
    end

    assign nw = small_sigma1(win_in[63:32]) + win_in[223:192]
              + small_sigma0(win_in[479:448]) + win_in[511:480];
    assign win_out = {win_in[479:0], nw};

    sha2_round u_round (
      .cur (st_in),
      .w   (win_in[511:480]),
      .k   (K[t_q + 6'(i)]),
      .nxt (st_out)
    );
  end

  assign win_last  = g_round[UNROLL-1].win_out;
  assign work_last = g_round[UNROLL-1].st_out;
  assign last_step = ({1'b0, t_q} + 7'(UNROLL)) == 7'd64;
  assign iv_sel    = MODE224 ? IV224 : IV256;

  always_comb begin
    h_sum = '{a: h_q.a + work_q.a, b: h_q.b + work_q.b,
              c: h_q.c + work_q.c, d: h_q.d + work_q.d,
              e: h_q.e + work_q.e, f: h_q.f + work_q.f,
              g: h_q.g + work_q.g, h: h_q.h + work_q.h};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      t_q       <= '0;
      mode224_q <= 1'b0;
      done_q    <= 1'b0;
      h_q       <= '0;
      work_q    <= '0;
      w_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            w_q     <= BLOCK;
            t_q     <= '0;
            state_q <= ST_ROUND;
            if (FIRST) begin
              h_q       <= iv_sel;
              work_q    <= iv_sel;
              mode224_q <= MODE224;
            end else begin
              work_q <= h_q;
            end
          end
        end
        ST_ROUND: begin
          work_q <= work_last;
          w_q    <= win_last;
          t_q    <= t_q + T_STEP;
          if (last_step) state_q <= ST_FINAL;
        end
        ST_FINAL: begin
          h_q     <= h_sum;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign BUSY   = state_q != ST_IDLE;
  assign DONE   = done_q;
  assign DIGEST = {h_q[255:32], mode224_q ? 32'h0 : h_q.h};

endmodule

// File: tb/tb_sha2_round_engine.sv
// Scoreboard bench for sha2_round_engine at UNROLL 1, 4 and 16 using known SHA-256/224 vectors.
module tb_sha2_round_engine;

  localparam logic [511:0] ABC  = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] MSG1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] MSG2 = {{15{32'h0}}, 32'h000001c0};
  localparam logic [511:0] JUNK = {16{32'hdeadbeef}};

  localparam logic [255:0] D_ABC256 = {
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [255:0] D_ABC224 = {
    32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3,
    32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7, 32'h00000000};
  localparam logic [255:0] D_MSG_B1 = {
    32'h85e655d6, 32'h417a1795, 32'h3363376a, 32'h624cde5c,
    32'h76e09589, 32'hcac5f811, 32'hcc4b32c1, 32'hf20e533a};
  localparam logic [255:0] D_MSG = {
    32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
    32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
  localparam logic [255:0] IV256_V = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] IV224_V = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'h00000000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [2:0]   start, first, mode224, busy, done;
  logic [511:0] blk [3];
  logic [255:0] dig [3];

  int cyc = 0;
  always @(posedge clk) cyc++;

  sha2_round_engine #(.UNROLL(1)) u_dut1 (
    .CLK(clk), .RESET(reset), .START(start[0]), .FIRST(first[0]), .MODE224(mode224[0]),
    .BLOCK(blk[0]), .BUSY(busy[0]), .DONE(done[0]), .DIGEST(dig[0]));
  sha2_round_engine #(.UNROLL(4)) u_dut4 (
    .CLK(clk), .RESET(reset), .START(start[1]), .FIRST(first[1]), .MODE224(mode224[1]),
    .BLOCK(blk[1]), .BUSY(busy[1]), .DONE(done[1]), .DIGEST(dig[1]));
  sha2_round_engine #(.UNROLL(16)) u_dut16 (
    .CLK(clk), .RESET(reset), .START(start[2]), .FIRST(first[2]), .MODE224(mode224[2]),
    .BLOCK(blk[2]), .BUSY(busy[2]), .DONE(done[2]), .DIGEST(dig[2]));

  typedef struct {
    int           dut;
    logic [255:0] dig;
    int           at;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic int rounds_of(input int d);
    return (d == 0) ? 64 : (d == 1) ? 16 : 4;
  endfunction

  // DONE must appear R+2 posedge counts after the negedge at which START is driven.
  task automatic issue(input int d, input logic f, input logic m, input logic [511:0] b,
                       input logic [255:0] exp, input bit track);
    start[d]   = 1'b1;
    first[d]   = f;
    mode224[d] = m;
    blk[d]     = b;
    if (track) sb.push_back('{dut: d, dig: exp, at: cyc + rounds_of(d) + 2});
    @(negedge clk);
    start[d] = 1'b0;
    blk[d]   = JUNK;
  endtask

  task automatic wait_done(input int d, input int limit);
    int k = 0;
    while (done[d] !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (done[d] !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout dut%0d: DONE=0 after %0d cycles, required DONE=1", d, limit);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (done[d] === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done dut%0d: DONE=1 at cycle %0d, required no DONE", d, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("done_dut", 256'(d), 256'(mon_e.dut));
          chk("digest", dig[d], mon_e.dig);
          chk("done_cycle", 256'(cyc), 256'(mon_e.at));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset   = 1'b1;
    start   = '0;
    first   = '0;
    mode224 = '0;
    for (int d = 0; d < 3; d++) blk[d] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk("reset_busy", 256'(busy[d]), 256'd0);
      chk("reset_done", 256'(done[d]), 256'd0);
      chk("reset_digest", dig[d], 256'd0);
    end

    // UNROLL=1 "abc", with a junk START mid-block that must be ignored
    issue(0, 1'b1, 1'b0, ABC, D_ABC256, 1'b1);
    chk("iv256_view", dig[0], IV256_V);
    chk("busy_after_start", 256'(busy[0]), 256'd1);
    chk("no_done_at_start", 256'(done[0]), 256'd0);
    repeat (10) @(negedge clk);
    start[0] = 1'b1; first[0] = 1'b1; mode224[0] = 1'b1; blk[0] = JUNK;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, 100);
    chk("busy_at_done", 256'(busy[0]), 256'd0);

    issue(0, 1'b1, 1'b1, ABC, D_ABC224, 1'b1);
    chk("iv224_view", dig[0], IV224_V);
    wait_done(0, 100);

    // two-block chain, second block issued in the DONE cycle; MODE224 must be ignored
    issue(0, 1'b1, 1'b0, MSG1, D_MSG_B1, 1'b1);
    wait_done(0, 100);
    issue(0, 1'b0, 1'b1, MSG2, D_MSG, 1'b1);
    wait_done(0, 100);

    // reset mid-block: untracked start so any DONE is unexpected
    issue(0, 1'b1, 1'b0, ABC, '0, 1'b0);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_busy", 256'(busy[0]), 256'd0);
    chk("midreset_done", 256'(done[0]), 256'd0);
    chk("midreset_digest", dig[0], 256'd0);
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (done[0] === 1'b1) seen = 1'b1;
    end
    chk("no_done_after_reset", 256'(seen), 256'd0);
    issue(0, 1'b1, 1'b0, ABC, D_ABC256, 1'b1);
    wait_done(0, 100);

    // UNROLL=4
    issue(1, 1'b1, 1'b0, ABC, D_ABC256, 1'b1);
    wait_done(1, 40);
    issue(1, 1'b1, 1'b0, MSG1, D_MSG_B1, 1'b1);
    wait_done(1, 40);
    issue(1, 1'b0, 1'b0, MSG2, D_MSG, 1'b1);
    wait_done(1, 40);

    // UNROLL=16
    issue(2, 1'b1, 1'b0, ABC, D_ABC256, 1'b1);
    wait_done(2, 20);
    issue(2, 1'b1, 1'b1, ABC, D_ABC224, 1'b1);
    wait_done(2, 20);
    issue(2, 1'b1, 1'b0, MSG1, D_MSG_B1, 1'b1);
    wait_done(2, 20);
    issue(2, 1'b0, 1'b0, MSG2, D_MSG, 1'b1);
    wait_done(2, 20);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 256'(sb.size()), 256'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
